// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the two requester ports and the memory-controller side
//            of mem_arbiter into one interface.
// Ports    : pN_req/we/func3/addr/wdata  requester -> arbiter (N = 0, 1)
//            pN_gnt/done/rdata           arbiter -> requester
//            mem_read_En/mem_write_En/mem_func3/mem_address/mem_data_in
//                                        arbiter -> memory controller
//            mem_data_out/mem_ready      memory controller -> arbiter
//            busy                        arbiter status
// Modports : slave  - the arbiter's view
//            master - the view of the requesters and the memory controller
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // Port 0 (CPU load/store unit)
    logic                     p0_req;
    logic                     p0_we;
    logic [2:0]               p0_func3;
    logic [ADDRESS_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0]    p0_wdata;
    logic                     p0_gnt;
    logic                     p0_done;
    logic [DATA_WIDTH-1:0]    p0_rdata;

    // Port 1 (debug / program loader)
    logic                     p1_req;
    logic                     p1_we;
    logic [2:0]               p1_func3;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    p1_wdata;
    logic                     p1_gnt;
    logic                     p1_done;
    logic [DATA_WIDTH-1:0]    p1_rdata;

    // Memory controller side
    logic                     mem_read_En;
    logic                     mem_write_En;
    logic [2:0]               mem_func3;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_data_in;
    logic [DATA_WIDTH-1:0]    mem_data_out;
    logic                     mem_ready;

    logic                     busy;

    modport slave (
        input  p0_req, p0_we, p0_func3, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_func3, p1_addr, p1_wdata,
        input  mem_data_out, mem_ready,
        output p0_gnt, p0_done, p0_rdata,
        output p1_gnt, p1_done, p1_rdata,
        output mem_read_En, mem_write_En, mem_func3, mem_address, mem_data_in,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_func3, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_func3, p1_addr, p1_wdata,
        output mem_data_out, mem_ready,
        input  p0_gnt, p0_done, p0_rdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  mem_read_En, mem_write_En, mem_func3, mem_address, mem_data_in,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one data-memory controller between two requesters with
//            round-robin arbitration on ties. One access in flight at a time:
//            arbitrate in IDLE, pulse one enable in ISSUE, follow mem_ready
//            low (WAIT_BUSY) and back high (WAIT_DONE), then pulse done.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - mem_arbiter_if.slave (requester ports, memory side, busy)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input wire clk,
    input wire rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_FUNC3_LW = 3'b010;

    state_t r_state;
    state_t w_state_next;

    // Latched transaction
    logic                     r_owner;
    logic                     r_last_owner;
    logic                     r_we;
    logic [2:0]               r_mem_func3;
    logic [ADDRESS_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0]    r_mem_data_in;

    // Registered outputs
    logic                     r_p0_gnt;
    logic                     r_p1_gnt;
    logic                     r_p0_done;
    logic                     r_p1_done;
    logic [DATA_WIDTH-1:0]    r_p0_rdata;
    logic [DATA_WIDTH-1:0]    r_p1_rdata;
    logic                     r_mem_read_en;
    logic                     r_mem_write_en;
    logic                     r_busy;

    // Arbitration
    logic                     w_arb_valid;
    logic                     w_winner;
    logic                     w_win_we;
    logic [2:0]               w_win_func3;
    logic [ADDRESS_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0]    w_win_wdata;

    // Next-cycle output values
    logic                     w_p0_gnt_next;
    logic                     w_p1_gnt_next;
    logic                     w_p0_done_next;
    logic                     w_p1_done_next;
    logic                     w_rd_en_next;
    logic                     w_wr_en_next;
    logic                     w_complete;

    // A controller that is not idle (e.g. after the arbiter alone was reset
    // mid-access) must finish before anything new is arbitrated.
    assign w_arb_valid = (r_state == S_IDLE) && bus.mem_ready && (bus.p0_req || bus.p1_req);

    // Lone requester wins; on a tie the port that did not own last wins.
    assign w_winner    = (bus.p0_req && bus.p1_req) ? ~r_last_owner : bus.p1_req;
    assign w_win_we    = w_winner ? bus.p1_we    : bus.p0_we;
    assign w_win_func3 = w_winner ? bus.p1_func3 : bus.p0_func3;
    assign w_win_addr  = w_winner ? bus.p1_addr  : bus.p0_addr;
    assign w_win_wdata = w_winner ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are computed one cycle ahead so every port is a flop:
    // gnt/enable values are registered on the edge that enters ISSUE,
    // done on the edge that leaves WAIT_DONE.
    always_comb begin
        w_state_next   = r_state;
        w_p0_gnt_next  = 1'b0;
        w_p1_gnt_next  = 1'b0;
        w_rd_en_next   = 1'b0;
        w_wr_en_next   = 1'b0;
        w_p0_done_next = 1'b0;
        w_p1_done_next = 1'b0;
        w_complete     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_valid) begin
                    w_state_next  = S_ISSUE;
                    w_p0_gnt_next = ~w_winner;
                    w_p1_gnt_next = w_winner;
                    w_rd_en_next  = ~w_win_we;
                    w_wr_en_next  = w_win_we;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.mem_ready) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.mem_ready) begin
                    w_state_next   = S_IDLE;
                    w_complete     = 1'b1;
                    w_p0_done_next = ~r_owner;
                    w_p1_done_next = r_owner;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner        <= 1'b0;
            r_last_owner   <= 1'b1;
            r_we           <= 1'b0;
            r_mem_func3    <= c_FUNC3_LW;
            r_mem_address  <= '0;
            r_mem_data_in  <= '0;
            r_p0_gnt       <= 1'b0;
            r_p1_gnt       <= 1'b0;
            r_p0_done      <= 1'b0;
            r_p1_done      <= 1'b0;
            r_p0_rdata     <= '0;
            r_p1_rdata     <= '0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_p0_gnt       <= w_p0_gnt_next;
            r_p1_gnt       <= w_p1_gnt_next;
            r_p0_done      <= w_p0_done_next;
            r_p1_done      <= w_p1_done_next;
            r_mem_read_en  <= w_rd_en_next;
            r_mem_write_en <= w_wr_en_next;
            r_busy         <= (w_state_next != S_IDLE);

            if (w_arb_valid) begin
                r_owner       <= w_winner;
                r_last_owner  <= w_winner;
                r_we          <= w_win_we;
                r_mem_func3   <= w_win_func3;
                r_mem_address <= w_win_addr;
                r_mem_data_in <= w_win_wdata;
            end

            // Only loads update rdata; it then holds until the next load
            // completion on the same port.
            if (w_complete && !r_we) begin
                if (r_owner) begin
                    r_p1_rdata <= bus.mem_data_out;
                end else begin
                    r_p0_rdata <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.p0_gnt       = r_p0_gnt;
    assign bus.p1_gnt       = r_p1_gnt;
    assign bus.p0_done      = r_p0_done;
    assign bus.p1_done      = r_p1_done;
    assign bus.p0_rdata     = r_p0_rdata;
    assign bus.p1_rdata     = r_p1_rdata;
    assign bus.mem_read_En  = r_mem_read_en;
    assign bus.mem_write_En = r_mem_write_en;
    assign bus.mem_func3    = r_mem_func3;
    assign bus.mem_address  = r_mem_address;
    assign bus.mem_data_in  = r_mem_data_in;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Contains a behavioural
//            memory controller, a transaction-level reference model checked
//            every cycle, and directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory semantics (RISC-V byte/half/word with sign/zero extension)
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * int'(addr[1:0])));
        h = 16'(word >> (16 * int'(addr[1])));
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000:  r[8 * int'(addr[1:0]) +: 8]  = wd[7:0];
            3'b001:  r[16 * int'(addr[1]) +: 16]  = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    logic [31:0] ctl_mem [0:63];
    logic [31:0] ref_mem [0:63];

    // ------------------------------------------------------------------
    // Memory controller: ready drops the cycle after the enable pulse;
    // loads stay busy 4 cycles, full-word stores 1, sub-word stores 2.
    // It is not reset with the arbiter.
    // ------------------------------------------------------------------
    logic        c_we;
    logic [31:0] c_addr;
    logic [2:0]  c_f3;
    logic [31:0] c_wd;
    int          c_low;

    initial begin
        bus.mem_ready    = 1'b1;
        bus.mem_data_out = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_read_En || bus.mem_write_En) begin
                c_we   = bus.mem_write_En;
                c_addr = bus.mem_address;
                c_f3   = bus.mem_func3;
                c_wd   = bus.mem_data_in;
                c_low  = c_we ? ((c_f3 == 3'b010) ? 1 : 2) : 4;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
                repeat (c_low) @(posedge clk);
                #1;
                if (c_we) begin
                    ctl_mem[c_addr[7:2]] = store_merge(ctl_mem[c_addr[7:2]], c_addr, c_f3, c_wd);
                end else begin
                    bus.mem_data_out = load_value(ctl_mem[c_addr[7:2]], c_addr, c_f3);
                end
                bus.mem_ready = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one transaction at a time, tracked by cycle number.
    // ------------------------------------------------------------------
    int          cyc;
    bit          m_active, m_seen_low, m_owner, m_we, m_last, m_done_owner, m_done_load;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_done_data;
    int          m_gnt_cyc, m_done_cyc;
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_addr, exp_wdata;
    logic [2:0]  exp_f3;

    task automatic model_reset();
        m_active     = 1'b0;
        m_seen_low   = 1'b0;
        m_last       = 1'b1;
        m_gnt_cyc    = -10;
        m_done_cyc   = -10;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        exp_addr     = 32'd0;
        exp_wdata    = 32'd0;
        exp_f3       = 3'b010;
    endtask

    task automatic cmp_all(input logic e_g0, input logic e_g1, input logic e_d0, input logic e_d1,
                           input logic e_rd, input logic e_wr, input logic e_busy);
        chk_bit("p0_gnt", bus.p0_gnt, e_g0);
        chk_bit("p1_gnt", bus.p1_gnt, e_g1);
        chk_bit("p0_done", bus.p0_done, e_d0);
        chk_bit("p1_done", bus.p1_done, e_d1);
        chk_bit("mem_read_En", bus.mem_read_En, e_rd);
        chk_bit("mem_write_En", bus.mem_write_En, e_wr);
        chk_bit("busy", bus.busy, e_busy);
        chk("p0_rdata", bus.p0_rdata, exp_rdata[0]);
        chk("p1_rdata", bus.p1_rdata, exp_rdata[1]);
        chk("mem_address", bus.mem_address, exp_addr);
        chk("mem_data_in", bus.mem_data_in, exp_wdata);
        chk("mem_func3", {29'd0, bus.mem_func3}, {29'd0, exp_f3});
    endtask

    initial begin
        bit w;
        cyc = 0;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_reset();
                cmp_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                continue;
            end
            if (cyc == m_done_cyc && m_done_load) exp_rdata[m_done_owner] = m_done_data;
            cmp_all(cyc == m_gnt_cyc && !m_owner, cyc == m_gnt_cyc && m_owner,
                    cyc == m_done_cyc && !m_done_owner, cyc == m_done_cyc && m_done_owner,
                    cyc == m_gnt_cyc && !m_we, cyc == m_gnt_cyc && m_we,
                    m_active && cyc >= m_gnt_cyc);
            if (!m_active && bus.mem_ready && (bus.p0_req || bus.p1_req)) begin
                w          = (bus.p0_req && bus.p1_req) ? !m_last : bus.p1_req;
                m_owner    = w;
                m_last     = w;
                m_we       = w ? bus.p1_we    : bus.p0_we;
                m_f3       = w ? bus.p1_func3 : bus.p0_func3;
                m_addr     = w ? bus.p1_addr  : bus.p0_addr;
                m_wdata    = w ? bus.p1_wdata : bus.p0_wdata;
                m_active   = 1'b1;
                m_seen_low = 1'b0;
                m_gnt_cyc  = cyc + 1;
                exp_addr   = m_addr;
                exp_f3     = m_f3;
                exp_wdata  = m_wdata;
            end else if (m_active && cyc > m_gnt_cyc) begin
                if (!m_seen_low) begin
                    if (!bus.mem_ready) m_seen_low = 1'b1;
                end else if (bus.mem_ready) begin
                    m_active     = 1'b0;
                    m_done_cyc   = cyc + 1;
                    m_done_owner = m_owner;
                    m_done_load  = !m_we;
                    if (m_we) ref_mem[m_addr[7:2]] = store_merge(ref_mem[m_addr[7:2]], m_addr, m_f3, m_wdata);
                    else      m_done_data = load_value(ref_mem[m_addr[7:2]], m_addr, m_f3);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int          g_first [2];
    int          d_first [2];
    int          n_gnt   [2];
    int          n_done  [2];
    int          n_rd, n_wr, n_overlap;
    int          order [$];
    logic [2:0]  gnt_f3;
    logic [31:0] gnt_addr;

    task automatic set_req(input int p, input logic on, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req = on; bus.p0_we = we; bus.p0_func3 = f3; bus.p0_addr = a; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = on; bus.p1_we = we; bus.p1_func3 = f3; bus.p1_addr = a; bus.p1_wdata = wd;
        end
    endtask

    // Watches ncyc cycles; k = 0 is the cycle in which the request was driven.
    task automatic observe(input int ncyc, input bit drop_on_gnt, input int max_grants);
        for (int p = 0; p < 2; p++) begin
            g_first[p] = -1; d_first[p] = -1; n_gnt[p] = 0; n_done[p] = 0;
        end
        n_rd = 0; n_wr = 0; n_overlap = 0;
        order.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.p0_gnt) begin
                if (g_first[0] < 0) g_first[0] = k;
                n_gnt[0]++; order.push_back(0);
                gnt_f3 = bus.mem_func3; gnt_addr = bus.mem_address;
                if (drop_on_gnt) bus.p0_req = 1'b0;
            end
            if (bus.p1_gnt) begin
                if (g_first[1] < 0) g_first[1] = k;
                n_gnt[1]++; order.push_back(1);
                gnt_f3 = bus.mem_func3; gnt_addr = bus.mem_address;
                if (drop_on_gnt) bus.p1_req = 1'b0;
            end
            if (max_grants > 0 && order.size() >= max_grants) begin
                bus.p0_req = 1'b0;
                bus.p1_req = 1'b0;
            end
            if (bus.p0_done) begin if (d_first[0] < 0) d_first[0] = k; n_done[0]++; end
            if (bus.p1_done) begin if (d_first[1] < 0) d_first[1] = k; n_done[1]++; end
            if (bus.mem_read_En) n_rd++;
            if (bus.mem_write_En) n_wr++;
            if (bus.mem_read_En && bus.mem_write_En) n_overlap++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ctl_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        ctl_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;   // 0x10
        ctl_mem[8] = 32'h80FF_0000; ref_mem[8] = 32'h80FF_0000;   // 0x20
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_func3", {29'd0, bus.mem_func3}, 32'd2);
        chk_bit("rst_busy", bus.busy, 1'b0);
        chk("rst_p0_rdata", bus.p0_rdata, 32'd0);
        rst = 1'b0;

        // Port 0 LW 0x10, port 1 idle
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        observe(12, 1'b1, 0);
        chk("s1_gnt_latency", 32'(g_first[0]), 32'd1);
        chk("s1_done_latency", 32'(d_first[0]), 32'd7);
        chk("s1_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
        chk("s1_read_pulses", 32'(n_rd), 32'd1);
        chk("s1_p1_activity", 32'(n_gnt[1] + n_done[1]), 32'd0);

        // Port 1 LB at 0x23 of word 0x80FF_0000
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 3'b000, 32'h23, 32'd0);
        observe(12, 1'b1, 0);
        chk("s4_gnt_latency", 32'(g_first[1]), 32'd1);
        chk("s4_mem_func3", {29'd0, gnt_f3}, 32'd0);
        chk("s4_mem_address", gnt_addr, 32'h23);
        chk("s4_done_latency", 32'(d_first[1]), 32'd7);
        chk("s4_p1_rdata", bus.p1_rdata, 32'hFFFF_FF80);

        // Reset, then simultaneous p0 SW / p1 LW to 0x20
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
        set_req(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        observe(16, 1'b1, 0);
        chk("s2_p0_gnt", 32'(g_first[0]), 32'd1);
        chk("s2_p0_done", 32'(d_first[0]), 32'd4);
        chk("s2_p1_gnt", 32'(g_first[1]), 32'd5);
        chk("s2_p1_done", 32'(d_first[1]), 32'd11);
        chk("s2_p1_rdata", bus.p1_rdata, 32'h1234_5678);

        // Both ports hold req for six accesses
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'hA5A5_0001);
        set_req(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
        observe(80, 1'b0, 6);
        chk("s3_grant_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            chk($sformatf("s3_grant_order_%0d", i), 32'(order[i]), 32'(i % 2));
        end
        chk("s3_enable_overlap", 32'(n_overlap), 32'd0);
        chk("s3_p1_rdata", bus.p1_rdata, 32'hA5A5_0001);

        // Reset during WAIT_DONE of a p0 load
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 3'b100, 32'h11, 32'd0);
        observe(4, 1'b1, 0);
        chk("s5_pre_mem_func3", {29'd0, bus.mem_func3}, 32'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_bit("s5_rst_busy", bus.busy, 1'b0);
        chk("s5_rst_mem_func3", {29'd0, bus.mem_func3}, 32'd2);
        chk("s5_rst_mem_address", bus.mem_address, 32'd0);
        chk("s5_rst_p1_rdata", bus.p1_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        observe(14, 1'b1, 0);
        chk("s5_gnt_after_ready", 32'(g_first[0]), 32'd2);
        chk("s5_done_count", 32'(n_done[0]), 32'd1);
        chk("s5_done_latency", 32'(d_first[0]), 32'd8);
        chk("s5_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
